// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg
// Shared constants for the TPU output path: the default datapath widths used by
// the adder and accumulation stages, and the accumulation FSM state encoding.
// -----------------------------------------------------------------------------
package tpu_pkg;

  // Default widths shared with the ripple-carry adder stage.
  localparam int DATA_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;
  localparam int CNT_W_DEF  = 8;

  // Accumulation FSM state encoding.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_ACCUM = S_ACCUM,
    ST_HOLD  = S_HOLD
  } state_e;

endpackage

// File: rtl/acc_add.sv
// -----------------------------------------------------------------------------
// acc_add
// Combinational ACC_W-bit signed adder built as a ripple chain of fa_cell.
// Ports:
//   a   : accumulator operand (signed)
//   b   : sign-extended term operand (signed)
//   sum : a + b, wrapped (or clamped, see below)
//   ovf : signed overflow of a + b
// Build option: when ACCUM_STAGE_SATURATE_EN is defined, an overflowing sum is
// clamped to the most positive / most negative value following the operand
// sign; otherwise the sum wraps modulo 2^ACC_W.
// -----------------------------------------------------------------------------
module acc_add
  import tpu_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] raw_sum_s;
  logic             msb_cin_s;
  logic             msb_cout_s;

  // Each stage keeps its own carry nets so the chain is a plain ripple.
  for (genvar i = 0; i < ACC_W; i++) begin : g_bit
    logic cin_s;
    logic cout_s;
    if (i == 0) begin : g_lsb
      assign cin_s = 1'b0;
    end else begin : g_rest
      assign cin_s = g_bit[i-1].cout_s;
    end
    fa_cell u_fa (
      .a_i (a[i]),
      .b_i (b[i]),
      .c_i (cin_s),
      .s_o (raw_sum_s[i]),
      .c_o (cout_s)
    );
  end

  assign msb_cin_s  = g_bit[ACC_W-1].cin_s;
  assign msb_cout_s = g_bit[ACC_W-1].cout_s;

  // Carry into the sign bit differing from carry out of it is exactly the
  // "equal operand signs, different result sign" condition.
  assign ovf = msb_cin_s ^ msb_cout_s;

`ifdef ACCUM_STAGE_SATURATE_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Clamp toward the common operand sign on overflow.
  always_comb begin
    sum = raw_sum_s;
    if (ovf) begin
      sum = a[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      sum = raw_sum_s;
    end
  end
`else
  assign sum = raw_sum_s;
`endif

endmodule

// File: rtl/fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
// One-bit full-adder cell, the building block of the ripple-carry adders.
// Ports:
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : sum bit
//   c_o      : carry out
// -----------------------------------------------------------------------------
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/accum_stage.sv
// -----------------------------------------------------------------------------
// accum_stage
// Accumulates a stream of signed partial sums into a wide accumulator and
// emits one result per group (group closed by in_last). Valid/ready on both
// sides; the result is held stable until the consumer takes it.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   in_valid/in_ready: input handshake; in_ready is low only while a result
//                      is held
//   in_data, in_last : signed partial sum, group delimiter
//   out_valid/out_ready : output handshake
//   out_data         : accumulated signed sum (ACC_W bits)
//   out_count        : number of terms in the group, saturating
//   out_ovf          : sticky signed-overflow flag for the group
// Build option: ACCUM_STAGE_SATURATE_EN selects clamping accumulation
// (implemented inside acc_add); default is wraparound.
// -----------------------------------------------------------------------------
module accum_stage
  import tpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;

  logic [ACC_W-1:0]  term_s;
  logic [ACC_W-1:0]  sum_s;
  logic              add_ovf_s;
  logic              accept_s;
  logic              xfer_s;

  assign term_s   = ACC_W'($signed(in_data));
  // Decoded from the state register only, so out_ready never reaches it.
  assign in_ready = (state_q != ST_HOLD);
  assign accept_s = in_valid && in_ready;
  assign xfer_s   = out_valid_q && out_ready;

  acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .a   (acc_q),
    .b   (term_s),
    .sum (sum_s),
    .ovf (add_ovf_s)
  );

  // Next-state and datapath update for the IDLE/ACCUM/HOLD sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          // First term loads directly; no add, so no overflow possible.
          acc_d   = term_s;
          cnt_d   = CNT_ONE;
          ovf_d   = 1'b0;
          state_d = in_last ? ST_HOLD : ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s) begin
          acc_d   = sum_s;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
          ovf_d   = ovf_q | add_ovf_s;
          state_d = in_last ? ST_HOLD : ST_ACCUM;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (xfer_s) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    out_valid_d = (state_d == ST_HOLD);
  end

  // State and result registers; reset discards any partial group.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: doc/accum_stage.md
Name: accum_stage

Overview:
- Accumulation stage directly downstream of the ripple-carry adder datapath in the TPU output path.
- Consumes a stream of signed partial sums (one column of the systolic array) and adds them into a wide accumulator.
- Emits one accumulated result per group, with the group delimited by `in_last`.
- Uses valid/ready handshakes on both sides, so it can stall the array or be stalled by the writeback buffer.

Parameters:
- DATA_W, 32: width of each incoming signed partial sum.
- ACC_W, 40: accumulator and result width; must be at least DATA_W.
- CNT_W, 8: width of the term counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  an input term is presented.
- in_ready  output  1  the stage can accept a term this cycle.
- in_data  input  DATA_W  signed two's-complement partial sum.
- in_last  input  1  the current term closes the group.
- out_valid  output  1  a result is held on the out_* ports.
- out_ready  input  1  the consumer takes the result.
- out_data  output  ACC_W  accumulated signed sum.
- out_count  output  CNT_W  number of terms in the group.
- out_ovf  output  1  signed overflow occurred at least once in the group (sticky).

Behaviour:
- Reset:
  - Asserting reset (low) asynchronously forces state=IDLE, acc=0, count=0, ovf=0, out_valid=0.
  - in_ready reads 1 as soon as reset is released.
  - Reset mid-group discards the partial accumulation; no result is emitted.
- Accept and transfer rules:
  - A term is accepted when in_valid && in_ready at a rising clk edge.
  - A result transfers when out_valid && out_ready.
- in_ready = (state != HOLD). There is no combinational path from out_ready to in_ready.
- Arithmetic:
  - in_data is sign-extended to ACC_W, then added to acc with ACC_W-bit wraparound.
  - ovf is set when both operands have equal sign and the sum's sign differs.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - On accept: acc <= sext(in_data), count <= 1, ovf <= 0.
  - Next state is HOLD if in_last, otherwise ACCUM.
- ACCUM:
  - On accept: acc <= acc + sext(in_data), count <= count + 1, ovf <= ovf | overflow.
  - Next state is HOLD if in_last.
  - count saturates at 2^CNT_W-1 and never wraps.
  - If there is no accept, all state holds (bubbles are allowed).
- HOLD:
  - out_valid=1. out_data=acc, out_count=count and out_ovf=ovf stay stable until the transfer.
  - On transfer: state returns to IDLE, acc=0, count=0, ovf=0, out_valid=0 on the next edge.
  - A new term is first accepted the cycle after the transfer.
- Latency:
  - The result is valid the cycle after the in_last term is accepted.
  - A single-term group (in_last on the first term) takes 1 cycle to HOLD.
  - Minimum throughput is one group per N+1 cycles for an N-term group.
- in_last is ignored when in_valid=0. in_data and in_last are don't-care when they are not accepted.
- out_* are registered outputs and carry no combinational input.

Optional Feature:
- Macro: ACCUM_STAGE_SATURATE_EN.
- Defined: on signed overflow, acc clamps to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)) according to operand sign. The clamp persists for later terms: it is re-evaluated each add. out_ovf behaves as without the macro.
- Undefined: plain wraparound, and out_ovf is the only overflow indication.

Decomposition:
- Shared package tpu_pkg holds:
  - the state encoding localparams: S_IDLE=2'd0, S_ACCUM=2'd1, S_HOLD=2'd2;
  - the default DATA_W and ACC_W constants shared with the adder stage.
- One sub-module, acc_add: a combinational ACC_W-bit signed adder.
  - Inputs: a, b. Outputs: sum, ovf.
  - Built structurally from the existing full-adder cell.
  - Holds the saturation logic under the macro.
- The FSM and registers stay in accum_stage.

Test Plan:
- Async reset applied mid-ACCUM after 3 terms, with clk stopped → out_valid=0 and in_ready=1 immediately; the next group starts from acc=0.
- Terms 5, -3, 10 (last), out_ready=1 → out_data=12, out_count=3, out_ovf=0, out_valid one cycle after the last accept.
- Single term -7 with in_last → HOLD next cycle, out_data=-7 sign-extended, out_count=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD, with in_valid=1 and new data → in_ready=0, outputs stable, and the next term is accepted only after the transfer.
- Overflow, ACC_W=40: two terms of 0x7FFFFFFF and acc preloaded near max via 256 terms of 0x7FFFFFFF →
  - out_count saturates at 255;
  - out_ovf=1;
  - out_data is the wrapped value, or 0x7FFFFFFFFF with the macro defined.
- Bubbles: in_valid toggled 1,0,0,1,1(last) with values 1,2,3 → out_data=6, out_count=3.
